// File: rtl/inst_rom_arbiter_pkg.sv
// Shared types and constants for the instruction ROM arbiter.
// Holds the bus widths, the zero word, the arbiter state encoding and
// the default starvation limit used by the top-level parameter.
package inst_rom_arbiter_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    // Default number of back-to-back fetch wins tolerated while debug waits.
    localparam int STARVE_LIMIT_DEF = 4;

    // Arbiter states: fetch has priority, or one debug grant is being forced.
    typedef enum logic [0:0] {
        S_FETCH_PRI = 1'b0,
        S_DBG_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/inst_rom_arbiter.sv
// Instruction ROM arbiter: shares one combinational ROM between the fetch
// stage and a debug/loader read port.
//  - Per-cycle arbitration, fetch has priority.
//  - Debug is forced in after STARVE_LIMIT consecutive fetch wins.
//  - The ROM word is registered, so read data arrives one cycle after grant.
//  - stall_req tells ctrl whenever a fetch request is denied.
// Optional build macro INST_ARB_ALIGN_CHK_EN adds if_err/dbg_err. When it is
// defined, misaligned requests are not issued and return a zero word with err.
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   if_req,
    input  logic [INST_ADDR_W-1:0] if_addr,
    input  logic                   if_flush,
    output logic                   if_gnt,
    output logic                   if_rvalid,
    output logic [INST_W-1:0]      if_rdata,

    input  logic                   dbg_req,
    input  logic [INST_ADDR_W-1:0] dbg_addr,
    output logic                   dbg_gnt,
    output logic                   dbg_rvalid,
    output logic [INST_W-1:0]      dbg_rdata,

`ifdef INST_ARB_ALIGN_CHK_EN
    output logic                   if_err,
    output logic                   dbg_err,
`endif

    output logic                   rom_ce,
    output logic [INST_ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0]      rom_inst,

    output logic                   stall_req
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_e             state;
    arb_state_e             state_next;
    logic [CNT_W-1:0]       starve_cnt;
    logic [CNT_W-1:0]       cnt_next;

    logic [INST_ADDR_W-1:0] win_addr;
    logic                   addr_ok;
    logic                   if_rvalid_q;

    // Arbitration, starvation counting and next state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned (which would infer a latch).
        if_gnt     = 1'b0;
        dbg_gnt    = 1'b0;
        state_next = state;
        cnt_next   = starve_cnt;

        unique case (state)
            S_FETCH_PRI: begin
                if (if_req) begin
                    if_gnt = 1'b1;
                end else if (dbg_req) begin
                    dbg_gnt = 1'b1;
                end

                // Count only fetch wins that made debug wait; saturate at the limit.
                if (!dbg_req || dbg_gnt) begin
                    cnt_next = '0;
                end else if (if_gnt && (starve_cnt < LIMIT_C)) begin
                    cnt_next = starve_cnt + 1'b1;
                end

                if (dbg_req && (cnt_next == LIMIT_C)) begin
                    state_next = S_DBG_FORCE;
                end
            end

            S_DBG_FORCE: begin
                // Fetch is locked out; debug gets it if still asking. Either way
                // the forced window lasts one cycle.
                dbg_gnt    = dbg_req;
                cnt_next   = '0;
                state_next = S_FETCH_PRI;
            end

            default: begin
                cnt_next   = '0;
                state_next = S_FETCH_PRI;
            end
        endcase
    end

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FETCH_PRI;
            starve_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state      <= state_next;
            starve_cnt <= cnt_next;
        end
    end

    // Winner's address and whether it may be issued to the ROM.
    always_comb begin
        win_addr = if_gnt ? if_addr : dbg_addr;
`ifdef INST_ARB_ALIGN_CHK_EN
        addr_ok  = (win_addr[1:0] == 2'b00);
`else
        addr_ok  = 1'b1;
`endif
        rom_ce   = (if_gnt || dbg_gnt) && addr_ok;
        rom_addr = rom_ce ? win_addr : '0;
    end

    assign stall_req = if_req && !if_gnt;

    // A flush in the response cycle kills the fetch response that is being presented.
    assign if_rvalid = if_rvalid_q && !if_flush;

    // Response registers: capture the ROM word into the winner's rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rvalid_q <= 1'b0;
            if_rdata    <= ZERO_WORD;
            dbg_rvalid  <= 1'b0;
            dbg_rdata   <= ZERO_WORD;
        end else begin
            // A flush in the grant cycle drops the response and keeps old if_rdata.
            if_rvalid_q <= if_gnt && !if_flush;
            if (if_gnt && !if_flush) begin
                if_rdata <= addr_ok ? rom_inst : ZERO_WORD;
            end

            dbg_rvalid <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_rdata <= addr_ok ? rom_inst : ZERO_WORD;
            end
        end
    end

`ifdef INST_ARB_ALIGN_CHK_EN
    logic if_err_q;
    logic dbg_err_q;

    // Error flags for misaligned grants, presented together with rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_err_q  <= 1'b0;
            dbg_err_q <= 1'b0;
        end else begin
            if_err_q  <= if_gnt && !addr_ok;
            dbg_err_q <= dbg_gnt && !addr_ok;
        end
    end

    assign if_err  = if_err_q && if_rvalid;
    assign dbg_err = dbg_err_q && dbg_rvalid;
`endif

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter.
// A behavioural model (grant rule, fetch-win tally, one-cycle response
// pipeline) is checked against the DUT on every falling edge; directed
// literal checks pin the model on the key scenarios.
module tb_inst_rom_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_addr = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        stall_req;
`ifdef INST_ARB_ALIGN_CHK_EN
    logic        if_err, dbg_err;
`endif

    inst_rom_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
`ifdef INST_ARB_ALIGN_CHK_EN
        .if_err     (if_err),
        .dbg_err    (dbg_err),
`endif
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    // Combinational ROM: word i holds 0xC0DE_0000 | i.
    logic [31:0] rom_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    always_comb rom_inst = rom_mem[rom_addr[7:2]];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_wins;          // fetch wins in a row while debug was waiting
    logic        m_if_rv, m_dbg_rv, m_if_err, m_dbg_err;
    logic [31:0] m_if_rd, m_dbg_rd;

    always @(negedge clk) begin
        logic        forced, e_if_gnt, e_dbg_gnt, e_mis, e_ce, e_stall;
        logic [31:0] e_addr, w_addr, e_word;
        if (!rst) begin
            m_wins = 0;
            m_if_rv = 1'b0; m_dbg_rv = 1'b0; m_if_err = 1'b0; m_dbg_err = 1'b0;
            m_if_rd = '0;   m_dbg_rd = '0;
        end
        forced    = (m_wins >= LIMIT);
        e_if_gnt  = forced ? 1'b0 : if_req;
        e_dbg_gnt = forced ? dbg_req : (!if_req && dbg_req);
        w_addr    = e_if_gnt ? if_addr : dbg_addr;
`ifdef INST_ARB_ALIGN_CHK_EN
        e_mis     = (e_if_gnt || e_dbg_gnt) && (w_addr % 4 != 0);
`else
        e_mis     = 1'b0;
`endif
        e_ce      = (e_if_gnt || e_dbg_gnt) && !e_mis;
        e_addr    = e_ce ? w_addr : 32'h0;
        e_stall   = if_req && !e_if_gnt;

        check("if_gnt",     if_gnt,     e_if_gnt);
        check("dbg_gnt",    dbg_gnt,    e_dbg_gnt);
        check("rom_ce",     rom_ce,     e_ce);
        check("rom_addr",   rom_addr,   e_addr);
        check("stall_req",  stall_req,  e_stall);
        check("if_rvalid",  if_rvalid,  m_if_rv && !if_flush);
        check("if_rdata",   if_rdata,   m_if_rd);
        check("dbg_rvalid", dbg_rvalid, m_dbg_rv);
        check("dbg_rdata",  dbg_rdata,  m_dbg_rd);
`ifdef INST_ARB_ALIGN_CHK_EN
        check("if_err",     if_err,     m_if_rv && !if_flush && m_if_err);
        check("dbg_err",    dbg_err,    m_dbg_rv && m_dbg_err);
`endif

        if (rst) begin
            e_word    = e_mis ? 32'h0 : rom_mem[(w_addr / 4) % 64];
            m_if_rv   = e_if_gnt && !if_flush;
            m_if_err  = e_if_gnt && e_mis;
            if (e_if_gnt && !if_flush) m_if_rd = e_word;
            m_dbg_rv  = e_dbg_gnt;
            m_dbg_err = e_dbg_gnt && e_mis;
            if (e_dbg_gnt) m_dbg_rd = e_word;
            if (forced || !dbg_req || e_dbg_gnt) m_wins = 0;
            else if (e_if_gnt)                   m_wins = m_wins + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic ir, input logic [31:0] ia, input logic fl,
                         input logic dr, input logic [31:0] da);
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; if_flush = fl; dbg_req = dr; dbg_addr = da;
    endtask

    initial begin
        // Reset state.
        #3;
        check("rst if_rvalid",  if_rvalid,  1'b0);
        check("rst dbg_rvalid", dbg_rvalid, 1'b0);
        check("rst if_rdata",   if_rdata,   32'h0);
        check("rst dbg_rdata",  dbg_rdata,  32'h0);
        check("rst rom_ce",     rom_ce,     1'b0);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Fetch only, back to back.
        drive(1, 32'h0, 0, 0, 0);  #2;
        check("fetch0 gnt", if_gnt, 1'b1);
        check("fetch0 addr", rom_addr, 32'h0);
        drive(1, 32'h4, 0, 0, 0);  #2;
        check("fetch0 rvalid", if_rvalid, 1'b1);
        check("fetch0 rdata", if_rdata, 32'hC0DE_0000);
        drive(1, 32'h8, 0, 0, 0);  #2;
        check("fetch1 rdata", if_rdata, 32'hC0DE_0001);
        drive(0, 0, 0, 0, 0);      #2;
        check("fetch2 rdata", if_rdata, 32'hC0DE_0002);
        check("fetch stall", stall_req, 1'b0);

        // Debug only.
        drive(0, 0, 0, 1, 32'h10); #2;
        check("dbg gnt", dbg_gnt, 1'b1);
        check("dbg addr", rom_addr, 32'h10);
        drive(0, 0, 0, 0, 0);      #2;
        check("dbg rvalid", dbg_rvalid, 1'b1);
        check("dbg rdata", dbg_rdata, 32'hC0DE_0004);
        check("dbg if_rvalid", if_rvalid, 1'b0);

        // Contention: four fetch wins, forced debug, then fetch again.
        for (int c = 0; c < 6; c++) begin
            drive(1, 32'h40 + 32'(4 * c), 0, 1, 32'h80); #2;
            if (c < 4) begin
                check("cont fetch gnt", if_gnt, 1'b1);
                check("cont dbg held", dbg_gnt, 1'b0);
            end else if (c == 4) begin
                check("cont force dbg", dbg_gnt, 1'b1);
                check("cont force if", if_gnt, 1'b0);
                check("cont force stall", stall_req, 1'b1);
            end else begin
                check("cont fetch again", if_gnt, 1'b1);
            end
        end
        drive(0, 0, 0, 0, 0);

        // Flush in grant cycle, then in response cycle.
        drive(1, 32'h24, 0, 0, 0);
        drive(1, 32'h20, 1, 0, 0);
        drive(0, 0, 0, 1, 32'h30); #2;
        check("flush rvalid", if_rvalid, 1'b0);
        check("flush rdata kept", if_rdata, 32'hC0DE_0009);
        check("flush dbg gnt", dbg_gnt, 1'b1);
        drive(1, 32'h2C, 1, 0, 0); #2;
        check("flush dbg rvalid", dbg_rvalid, 1'b1);
        check("flush dbg rdata", dbg_rdata, 32'hC0DE_000C);
        drive(1, 32'h2C, 0, 0, 0);
        drive(0, 0, 1, 0, 0);      #2;
        check("flush resp rvalid", if_rvalid, 1'b0);
        check("flush resp rdata", if_rdata, 32'hC0DE_000B);
        drive(0, 0, 0, 0, 0);

        // Reset in the middle of a debug read.
        drive(0, 0, 0, 1, 32'h8); #2;
        check("mid dbg gnt", dbg_gnt, 1'b1);
        #1 rst = 1'b0;
        #2;
        check("mid rst dbg_rvalid", dbg_rvalid, 1'b0);
        check("mid rst dbg_rdata", dbg_rdata, 32'h0);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(1, 32'h50, 0, 1, 32'h54); #2;
        check("post rst fetch pri", if_gnt, 1'b1);
        drive(0, 0, 0, 0, 0);

        // Mixed traffic, checked by the model.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a, b;
            a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            b = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
`ifdef INST_ARB_ALIGN_CHK_EN
            a[1:0] = 2'($urandom_range(0, 3));
`endif
            drive(1'($urandom_range(0, 1)), a, ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), b);
        end
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

`ifdef INST_ARB_ALIGN_CHK_EN
        // Misaligned fetch is not issued and returns an error.
        drive(1, 32'h6, 0, 0, 0); #2;
        check("align rom_ce", rom_ce, 1'b0);
        drive(0, 0, 0, 0, 0);     #2;
        check("align rvalid", if_rvalid, 1'b1);
        check("align err", if_err, 1'b1);
        check("align rdata", if_rdata, 32'h0);
        drive(0, 0, 0, 0, 0);
`endif

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_rom_arbiter.md
Name: inst_rom_arbiter

Overview:
- Shares the single combinational instruction ROM between two requesters: the CPU fetch stage (pc_reg/IF) and a debug/loader read port.
- Arbitrates per cycle and drives rom ce/addr.
- Registers the returned word, so read data is valid one cycle after grant.
- Raises a stall request to ctrl whenever fetch is denied.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive fetch grants while dbg_req is pending before debug is forced. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch byte address (`InstAddrBus).
- if_flush  in  1  branch/exception flush; kills the in-flight fetch response.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  32  fetch instruction (`InstBus).
- dbg_req  in  1  debug read request.
- dbg_addr  in  32  debug byte address.
- dbg_gnt  out  1  debug granted this cycle.
- dbg_rvalid  out  1  debug response valid.
- dbg_rdata  out  32  debug read word.
- rom_ce  out  1  ROM chip enable.
- rom_addr  out  32  ROM byte address.
- rom_inst  in  32  ROM combinational read data.
- stall_req  out  1  to ctrl: if_req && !if_gnt.

Behaviour:
- Reset (rst=0, asynchronous):
  - if_rvalid=0, dbg_rvalid=0, if_rdata=`ZeroWord, dbg_rdata=`ZeroWord.
  - starve_cnt=0, state=S_FETCH_PRI.
  - Combinational outputs follow their equations; ROM is not enabled unless a request is present.
- Handshake:
  - A requester holds req and addr stable until it sees gnt. It may drop req before gnt with no side effects.
  - gnt is asserted in the same cycle as req when the requester wins arbitration.
  - Exactly one read is issued per gnt cycle.
  - Back-to-back grants to the same requester are allowed, giving one word per cycle.
- Issue:
  - rom_ce = if_gnt | dbg_gnt.
  - rom_addr = winner's address; 0 when no grant.
  - if_gnt and dbg_gnt are never both 1.
- Response:
  - At the edge ending a grant cycle, rom_inst is captured into the winner's rdata register and its rvalid is set for exactly one cycle. Latency is 1.
  - rdata holds its last value when rvalid=0.
- States:
  - S_FETCH_PRI:
    - if_req wins when present, else dbg_req.
    - Each cycle with if_gnt && dbg_req: starve_cnt increments.
    - When starve_cnt reaches STARVE_LIMIT with dbg_req still pending: go to S_DBG_FORCE.
    - Whenever dbg_req=0 or dbg_gnt=1: starve_cnt clears.
  - S_DBG_FORCE:
    - dbg_req wins unconditionally for one grant; fetch is denied, so stall_req=1 if if_req.
    - After the debug grant: starve_cnt=0, return to S_FETCH_PRI.
    - If dbg_req drops before being granted: return to S_FETCH_PRI with no grant.
- Flush:
  - if_flush=1 in the grant cycle suppresses the following if_rvalid. The ROM read still occurs; if_rdata is unchanged.
  - if_flush=1 in the response cycle forces if_rvalid=0 in that cycle.
  - if_flush has no effect on the debug path or on arbitration.
- Boundaries:
  - Both requests idle: rom_ce=0, no state change.
  - Address is forwarded unmodified; the ROM uses word bits.
  - starve_cnt saturates at STARVE_LIMIT and never wraps.
- Reset mid-transaction:
  - The in-flight response is dropped and rvalid=0 immediately.
  - Requesters re-request after reset release.

Optional Feature:
- Macro: INST_ARB_ALIGN_CHK_EN.
- Defined:
  - Adds outputs if_err and dbg_err (1 bit each), valid together with rvalid.
  - A granted request with addr[1:0]!=0 is not issued: rom_ce=0 that cycle.
  - Next cycle: rvalid=1, rdata=`ZeroWord, err=1.
  - Aligned requests give err=0.
- Undefined:
  - No err ports.
  - Misaligned addresses are issued as-is; the ROM ignores bits [1:0].

Decomposition:
- Shared define.vh holds:
  - existing `InstAddrBus, `InstBus, `ZeroWord;
  - new `ArbStateBus, `S_FETCH_PRI, `S_DBG_FORCE, `StarveLimitDef.
- Single module. No sub-module: the arbiter FSM and response registers are too small to split.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0,0x4,0x8 on consecutive cycles → if_gnt=1 each cycle; if_rvalid=1 one cycle later with rom words 0,1,2; stall_req=0.
- Debug only: dbg_req=1, dbg_addr=0x10 → dbg_gnt=1, rom_addr=0x10; next cycle dbg_rvalid=1, dbg_rdata=mem[4]; if_rvalid=0.
- Contention with STARVE_LIMIT=4: if_req and dbg_req held high →
  - fetch granted cycles 0-3;
  - cycle 4: dbg_gnt=1, if_gnt=0, stall_req=1;
  - cycle 5: fetch granted again, starve_cnt=0.
- Flush: grant fetch at 0x20 with if_flush=1 that cycle → next cycle if_rvalid=0, if_rdata unchanged; debug unaffected.
- Reset mid-read: grant dbg at 0x8, assert rst=0 before the edge → dbg_rvalid=0, dbg_rdata=0 immediately; state=S_FETCH_PRI after release.
- INST_ARB_ALIGN_CHK_EN: if_addr=0x6 → rom_ce=0; next cycle if_rvalid=1, if_err=1, if_rdata=0.
